// File: rtl/alu_exec_if.sv
// Bus between the fetch controller (master) and the execute stage (slave):
// the request side carries op/operands and the response side carries result and status.
interface alu_exec_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 5
);
  logic             start;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             err;
  logic             halt;

  modport master (
    output start, op, a, b,
    input  busy, done, result, flags, err, halt
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, flags, err, halt
  );
endinterface

// File: rtl/alu_exec.sv
// Execute stage: single-cycle logic/arithmetic/shift ops plus WIDTH-iteration
// shift-add multiply and restoring divide, with a registered result and a done pulse.
module alu_exec #(
  parameter int WIDTH = 16,
  parameter int OPW   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(7);
  localparam logic [OPW-1:0] OP_SAR  = OPW'(8);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(9);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(10);
  localparam logic [OPW-1:0] OP_MOD  = OPW'(11);
  localparam logic [OPW-1:0] OP_HALT = OPW'(31);

  typedef enum logic {IDLE, ITER} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;
  logic               halt_q, halt_d;

  // Single-cycle datapath; shifts use a double-width window so the carry is the adjacent bit.
  logic [WIDTH:0]            sum_w, dif_w;
  logic [2*WIDTH-1:0]        shl_w, shr_w;
  logic signed [2*WIDTH-1:0] sar_w;
  logic [3:0]                sh;
  logic [WIDTH-1:0]          sc_res;
  logic                      sc_c, sc_v, sc_err, sc_ill, sc_multi, sc_halt;
  logic [3:0]                sc_flags;

  assign sh    = bus.b[3:0];
  assign sum_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign dif_w = {1'b0, bus.a} - {1'b0, bus.b};
  assign shl_w = {{WIDTH{1'b0}}, bus.a} << sh;
  assign shr_w = {bus.a, {WIDTH{1'b0}}} >> sh;
  assign sar_w = $signed({bus.a, {WIDTH{1'b0}}}) >>> sh;

  always_comb begin
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_err   = 1'b0;
    sc_ill   = 1'b0;
    sc_multi = 1'b0;
    sc_halt  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif_w[WIDTH-1:0];
        sc_c   = dif_w[WIDTH];
        sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: sc_res = bus.a & bus.b;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_XOR: sc_res = bus.a ^ bus.b;
      OP_NOT: sc_res = ~bus.a;
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[2*WIDTH-1:WIDTH];
        sc_c   = shr_w[WIDTH-1];
      end
      OP_SAR: begin
        sc_res = sar_w[2*WIDTH-1:WIDTH];
        sc_c   = sar_w[WIDTH-1];
      end
      OP_MUL: sc_multi = 1'b1;
      OP_DIV, OP_MOD: begin
        if (bus.b == '0) begin
          sc_res = (bus.op == OP_DIV) ? '1 : bus.a;
          sc_err = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      OP_HALT: sc_halt = 1'b1;
      default: begin
        sc_err = 1'b1;
        sc_ill = 1'b1;
      end
    endcase
    sc_flags = sc_ill ? 4'b0000 : {sc_res == '0, sc_res[WIDTH-1], sc_c, sc_v};
  end

  // Iteration datapath: acc holds the product for MUL, {remainder, quotient} for DIV/MOD.
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     rem_sh, rem_nxt;
  logic               div_ge;
  logic [WIDTH-1:0]   quo_nxt, it_res;
  logic               it_c;

  always_comb begin
    mul_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], mcand_q[WIDTH-1]};
    div_ge  = rem_sh >= {1'b0, mplr_q};
    rem_nxt = div_ge ? (rem_sh - {1'b0, mplr_q}) : rem_sh;
    quo_nxt = {acc_q[WIDTH-2:0], div_ge};
    it_c    = 1'b0;
    if (op_q == OP_MUL) begin
      it_res = mul_sum[WIDTH-1:0];
      it_c   = |mul_sum[2*WIDTH-1:WIDTH];
    end else if (op_q == OP_DIV) begin
      it_res = quo_nxt;
    end else begin
      it_res = rem_nxt[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    halt_d   = halt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (sc_multi) begin
            state_d = ITER;
            op_d    = bus.op;
            mcand_d = {{WIDTH{1'b0}}, bus.a};
            mplr_d  = bus.b;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            done_d = 1'b1;
            if (sc_halt) begin
              halt_d = 1'b1;
              err_d  = 1'b0;
            end else begin
              result_d = sc_res;
              flags_d  = sc_flags;
              err_d    = sc_err;
            end
          end
        end
      end
      ITER: begin
        cnt_d   = cnt_q + CW'(1);
        mcand_d = mcand_q << 1;
        if (op_q == OP_MUL) begin
          acc_d  = mul_sum;
          mplr_d = mplr_q >> 1;
        end else begin
          acc_d = {rem_nxt[WIDTH-1:0], quo_nxt};
        end
        if (cnt_q == LAST) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          err_d    = 1'b0;
          result_d = it_res;
          flags_d  = {it_res == '0, it_res[WIDTH-1], it_c, 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      halt_q   <= halt_d;
    end
  end

  assign bus.busy   = (state_q == ITER);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.err    = err_q;
  assign bus.halt   = halt_q;
endmodule

// File: tb/tb_alu_exec.sv
// Randomized and directed bench for alu_exec against an arithmetic reference model.
module tb_alu_exec;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] model_res   = '0;
  logic [3:0]  model_flags = '0;
  logic        model_halt  = 1'b0;

  alu_exec_if #(.WIDTH(16), .OPW(5)) bus ();

  alu_exec #(.WIDTH(16), .OPW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result/flags/err/latency straight from the opcode definitions.
  task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [3:0] f, output logic e,
                       output int lat);
    int sa, sb, s, shamt;
    logic [31:0] u;
    logic c, v, is_halt, is_ill;
    sa = int'($signed(a));
    sb = int'($signed(b));
    shamt = int'(b[3:0]);
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1; is_halt = 1'b0; is_ill = 1'b0;
    case (op)
      5'd0: begin
        u = 32'(a) + 32'(b); r = u[15:0]; c = (u > 32'hFFFF);
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      5'd1: begin
        r = a - b; c = (a < b);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = ~a;
      5'd6: begin
        u = 32'(a) << shamt; r = u[15:0];
        c = (shamt != 0) && (((32'(a) >> (16 - shamt)) & 32'd1) != 0);
      end
      5'd7: begin
        r = a >> shamt;
        c = (shamt != 0) && (((32'(a) >> (shamt - 1)) & 32'd1) != 0);
      end
      5'd8: begin
        s = sa >>> shamt; r = 16'(s);
        c = (shamt != 0) && (((sa >>> (shamt - 1)) & 1) != 0);
      end
      5'd9: begin
        u = 32'(a) * 32'(b); r = u[15:0]; c = (u[31:16] != 0); lat = 17;
      end
      5'd10: if (b == 0) begin r = 16'hFFFF; e = 1'b1; end else begin r = a / b; lat = 17; end
      5'd11: if (b == 0) begin r = a; e = 1'b1; end else begin r = a % b; lat = 17; end
      5'd31: is_halt = 1'b1;
      default: begin is_ill = 1'b1; e = 1'b1; end
    endcase
    if (is_halt) begin
      r = model_res; f = model_flags; model_halt = 1'b1;
    end else if (is_ill) begin
      f = 4'b0000;
    end else begin
      f = {r == 16'h0, r[15], c, v};
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit inject);
    logic [15:0] er;
    logic [3:0]  ef;
    logic        ee;
    int          el, lat, bcnt, extra;
    model(op, a, b, er, ef, ee, el);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      if (inject && lat == 3) begin
        bus.start = 1'b1; bus.op = 5'd0; bus.a = 16'd1; bus.b = 16'd1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    check($sformatf("latency op%0d", op), 32'(lat), 32'(el));
    check($sformatf("busy_cycles op%0d", op), 32'(bcnt), 32'(el - 1));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check($sformatf("result op%0d a=%0h b=%0h", op, a, b), 32'(bus.result), 32'(er));
    check($sformatf("flags op%0d a=%0h b=%0h", op, a, b), 32'(bus.flags), 32'(ef));
    check($sformatf("err op%0d", op), 32'(bus.err), 32'(ee));
    check("halt", 32'(bus.halt), 32'(model_halt));
    model_res = er;
    model_flags = ef;
    if (inject) begin
      extra = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (bus.done) extra++;
      end
      check("no_extra_done", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int dones;
    logic [4:0] rop;
    logic [15:0] ra, rb;
    int pick;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags",  32'(bus.flags),  32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_halt",   32'(bus.halt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(5'd0, 16'h7FFF, 16'h0001, 1'b0);
    check("add_plan_flags", 32'(bus.flags), 32'h5);
    run_op(5'd1, 16'd3, 16'd5, 1'b0);
    run_op(5'd7, 16'h8001, 16'h0011, 1'b0);
    run_op(5'd9, 16'h0123, 16'h0100, 1'b1);
    check("mul_plan_result", 32'(bus.result), 32'h2300);
    run_op(5'd10, 16'd100, 16'd7, 1'b0);
    run_op(5'd11, 16'd100, 16'd7, 1'b0);
    run_op(5'd10, 16'd100, 16'd0, 1'b0);
    run_op(5'd11, 16'd100, 16'd0, 1'b0);
    run_op(5'd6, 16'h8001, 16'h0000, 1'b0);
    run_op(5'd8, 16'h8000, 16'h000F, 1'b0);
    run_op(5'd31, 16'h1234, 16'h5678, 1'b0);
    run_op(5'd12, 16'h1111, 16'h2222, 1'b0);
    run_op(5'd0, 16'd5, 16'd5, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 5'd9; bus.a = 16'h0123; bus.b = 16'h0100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_done",   32'(bus.done),   32'd0);
    check("midrst_halt",   32'(bus.halt),   32'd0);
    model_res = '0; model_flags = '0; model_halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op(5'd0, 16'd2, 16'd2, 1'b0);
    check("post_rst_add", 32'(bus.result), 32'd4);

    for (int i = 0; i < 80; i++) begin
      pick = int'($urandom_range(0, 19));
      if (pick < 12)      rop = 5'(pick);
      else if (pick < 19) rop = 5'($urandom_range(0, 11));
      else                rop = 5'($urandom_range(12, 31));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_op(rop, ra, rb, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
